// File: rtl/hdlc_pkg.sv
// Shared types and constants for the HDLC receive path.
package hdlc_pkg;

    typedef enum logic [1:0] {IDLE, FILL, READY, DRAIN} rxbuf_state_t;

    localparam int FCS16_BYTES = 2;
    localparam int FCS32_BYTES = 4;

    // Width needed to hold a count of 0..max_frame inclusive.
    function automatic int size_w(input int max_frame);
        return $clog2(max_frame + 1);
    endfunction

endpackage

// File: rtl/hdlc_frame_ram.sv
// Simple dual-port frame store: one write port, one registered read port, no reset on contents.
module hdlc_frame_ram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 128,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/hdlc_rx_framebuff.sv
// HDLC receive frame buffer: stores one frame, strips the FCS trailer from the
// reported size, flags overflow / lost frames and serves the frame to the CPU.
module hdlc_rx_framebuff
    import hdlc_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int MAX_FRAME = 128,
    parameter int FCS_BYTES = FCS16_BYTES
) (
    input  logic                          Clk,
    input  logic                          Rst,
    input  logic                          Rx_ValidFrame,
    input  logic                          Rx_WrBuff,
    input  logic [DATA_W-1:0]             Rx_Data,
    input  logic                          Rx_EoF,
    input  logic                          Rx_AbortSignal,
    input  logic                          Rx_FrameError,
    input  logic                          Rx_FCSerr,
    input  logic                          Rx_RdBuff,
    input  logic                          Rx_Drop,
    output logic [DATA_W-1:0]             Rx_DataBuffOut,
    output logic [size_w(MAX_FRAME)-1:0]  Rx_FrameSize,
    output logic                          Rx_Ready,
    output logic                          Rx_Overflow,
    output logic                          Rx_FrameLost
);

    localparam int SW = size_w(MAX_FRAME);
    localparam int AW = $clog2(MAX_FRAME);
    localparam logic [SW-1:0] MAX_C = SW'(MAX_FRAME);
    localparam logic [SW-1:0] FCS_C = SW'(FCS_BYTES);

    rxbuf_state_t state, nxt;
    logic [SW-1:0] count, cnt_w, cnt_nxt;
    logic [SW-1:0] rd_ptr, rdp_nxt;
    logic [SW-1:0] size_q, size_nxt;
    logic          ovf_q, ovf_nxt;
    logic          lost_q, lost_nxt;
    logic          discard_q, disc_nxt;
    logic          out_zero, zero_nxt;
    logic          ram_we, ram_re, framing, busy_wr;
    logic [DATA_W-1:0] ram_rdata;

    // Frame boundaries come from the strobes alone; ValidFrame is kept on the port for compatibility.
    logic unused_valid_frame;
    assign unused_valid_frame = Rx_ValidFrame;

    hdlc_frame_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (MAX_FRAME)
    ) u_ram (
        .clk   (Clk),
        .we    (ram_we),
        .waddr (count[AW-1:0]),
        .wdata (Rx_Data),
        .re    (ram_re),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (ram_rdata)
    );

    always_comb begin
        nxt      = state;
        ram_we   = 1'b0;
        ram_re   = 1'b0;
        cnt_w    = count;
        rdp_nxt  = rd_ptr;
        size_nxt = size_q;
        ovf_nxt  = ovf_q;
        zero_nxt = out_zero;
        framing  = 1'b0;
        busy_wr  = 1'b0;

        unique case (state)
            IDLE: begin
                if (Rx_WrBuff && !discard_q) begin
                    ram_we  = 1'b1;
                    cnt_w   = SW'(1);
                    ovf_nxt = 1'b0;
                    nxt     = FILL;
                    framing = 1'b1;
                end
            end
            FILL: begin
                framing = 1'b1;
                if (Rx_WrBuff) begin
                    if (count < MAX_C) begin
                        ram_we = 1'b1;
                        cnt_w  = count + SW'(1);
                    end else begin
                        ovf_nxt = 1'b1;
                    end
                end
            end
            READY, DRAIN: begin
                busy_wr = Rx_WrBuff && !discard_q;
                if (Rx_Drop) begin
                    nxt = IDLE;
                end else if (Rx_RdBuff) begin
                    ram_re   = (rd_ptr < size_q);
                    zero_nxt = !(rd_ptr < size_q);
                    rdp_nxt  = rd_ptr + SW'(1);
                    nxt      = (rd_ptr + SW'(1) >= size_q) ? IDLE : DRAIN;
                end
            end
            default: nxt = IDLE;
        endcase

        // Reads outside a stored frame behave like reads past its end.
        if (Rx_RdBuff && (state == IDLE || state == FILL)) zero_nxt = 1'b1;

        cnt_nxt  = cnt_w;
        lost_nxt = busy_wr;
        if (framing) begin
            if (Rx_AbortSignal) begin
                nxt     = IDLE;
                cnt_nxt = '0;
            end else if (Rx_EoF) begin
                cnt_nxt = '0;
                if (Rx_FrameError || Rx_FCSerr || cnt_w <= FCS_C) begin
                    nxt      = IDLE;
                    lost_nxt = 1'b1;
                end else begin
                    nxt      = READY;
                    size_nxt = cnt_w - FCS_C;
                    rdp_nxt  = '0;
                end
            end
        end

        // Remainder of a frame refused while busy is skipped up to its end.
        disc_nxt = (discard_q || busy_wr) && !(Rx_EoF || Rx_AbortSignal);
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state     <= IDLE;
            count     <= '0;
            rd_ptr    <= '0;
            size_q    <= '0;
            ovf_q     <= 1'b0;
            lost_q    <= 1'b0;
            discard_q <= 1'b0;
            out_zero  <= 1'b1;
        end else begin
            state     <= nxt;
            count     <= cnt_nxt;
            rd_ptr    <= rdp_nxt;
            size_q    <= size_nxt;
            ovf_q     <= ovf_nxt;
            lost_q    <= lost_nxt;
            discard_q <= disc_nxt;
            out_zero  <= zero_nxt;
        end
    end

    assign Rx_DataBuffOut = out_zero ? '0 : ram_rdata;
    assign Rx_FrameSize   = size_q;
    assign Rx_Ready       = (state == READY) || (state == DRAIN);
    assign Rx_Overflow    = ovf_q;
    assign Rx_FrameLost   = lost_q;

endmodule

// File: tb/tb_hdlc_rx_framebuff.sv
// Scoreboard bench for hdlc_rx_framebuff: one instance at 128/FCS-16, one at 16/FCS-32.
module tb_hdlc_rx_framebuff;

    typedef logic [7:0] bq_t[$];

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, vf, wr, eof, abort, ferr, fcserr, rd, drop;
    logic [7:0] data;

    logic [7:0] d0_out, d1_out, s0;
    logic [4:0] s1;
    logic       r0, r1, ov0, ov1, l0, l1;

    hdlc_rx_framebuff #(.DATA_W(8), .MAX_FRAME(128), .FCS_BYTES(2)) u0 (
        .Clk(clk), .Rst(rst_n), .Rx_ValidFrame(vf), .Rx_WrBuff(wr), .Rx_Data(data),
        .Rx_EoF(eof), .Rx_AbortSignal(abort), .Rx_FrameError(ferr), .Rx_FCSerr(fcserr),
        .Rx_RdBuff(rd), .Rx_Drop(drop), .Rx_DataBuffOut(d0_out), .Rx_FrameSize(s0),
        .Rx_Ready(r0), .Rx_Overflow(ov0), .Rx_FrameLost(l0));

    hdlc_rx_framebuff #(.DATA_W(8), .MAX_FRAME(16), .FCS_BYTES(4)) u1 (
        .Clk(clk), .Rst(rst_n), .Rx_ValidFrame(vf), .Rx_WrBuff(wr), .Rx_Data(data),
        .Rx_EoF(eof), .Rx_AbortSignal(abort), .Rx_FrameError(ferr), .Rx_FCSerr(fcserr),
        .Rx_RdBuff(rd), .Rx_Drop(drop), .Rx_DataBuffOut(d1_out), .Rx_FrameSize(s1),
        .Rx_Ready(r1), .Rx_Overflow(ov1), .Rx_FrameLost(l1));

    logic       sel;
    logic [7:0] o_out, o_size;
    logic       o_rdy, o_ovf, o_lost;
    assign o_out  = sel ? d1_out : d0_out;
    assign o_size = sel ? {3'b000, s1} : s0;
    assign o_rdy  = sel ? r1 : r0;
    assign o_ovf  = sel ? ov1 : ov0;
    assign o_lost = sel ? l1 : l0;

    int checks = 0, failures = 0;
    int cur_max, cur_fcs;

    // Reference model: the stored frame as a list of bytes plus a read cursor.
    bit   e_busy, e_ovf;
    bq_t  e_mem;
    int   e_sz, e_rdptr, exp_lost, lost_seen;
    logic [7:0] exp_rd[$];
    int   exp_sz[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: pops expected read data / frame sizes as the DUT presents them.
    logic rd_v = 1'b0;
    logic rdy_d = 1'b0;
    always @(posedge clk) rd_v <= rd && rst_n;
    always @(negedge clk) begin
        if (rst_n) begin
            if (rd_v) begin
                if (exp_rd.size() == 0) chk("rd_unexpected", 1, 0);
                else chk("rd_data", o_out, exp_rd.pop_front());
            end
            if (o_rdy && !rdy_d) begin
                if (exp_sz.size() == 0) chk("ready_unexpected", 1, 0);
                else chk("frame_size", o_size, exp_sz.pop_front());
            end
            if (o_lost) lost_seen++;
        end
        rdy_d = o_rdy;
    end

    task automatic clk1;
        @(posedge clk); #1;
    endtask

    task automatic check_state(input string nm);
        @(negedge clk); #1;
        chk({nm, "_ready"}, o_rdy, e_busy);
        chk({nm, "_ovf"}, o_ovf, e_ovf);
        chk({nm, "_lost"}, lost_seen, exp_lost);
        @(posedge clk); #1;
    endtask

    task automatic do_reset;
        rst_n = 0; vf = 0; wr = 0; eof = 0; abort = 0; ferr = 0; fcserr = 0;
        rd = 0; drop = 0; data = 0;
        clk1;
        @(negedge clk); #1;
        chk("rst_out", o_out, 0);
        chk("rst_size", o_size, 0);
        chk("rst_ready", o_rdy, 0);
        chk("rst_ovf", o_ovf, 0);
        chk("rst_lost", o_lost, 0);
        @(posedge clk); #1;
        rst_n = 1;
        e_busy = 0; e_ovf = 0; e_mem.delete(); e_sz = 0; e_rdptr = 0;
    endtask

    task automatic model_frame(input bq_t fr, input bit err, input bit ab);
        int n, cnt;
        n = fr.size();
        if (e_busy) begin
            exp_lost++;
        end else begin
            e_ovf = (n > cur_max);
            if (!ab) begin
                cnt = (n > cur_max) ? cur_max : n;
                if (err || cnt <= cur_fcs) exp_lost++;
                else begin
                    e_busy = 1; e_rdptr = 0; e_sz = cnt - cur_fcs;
                    e_mem.delete();
                    for (int i = 0; i < cnt; i++) e_mem.push_back(fr[i]);
                    exp_sz.push_back(e_sz);
                end
            end
        end
    endtask

    task automatic send_frame(input bq_t fr, input bit fcs_e, input bit frm_e,
                              input bit ab, input bit eof_last, input int gap);
        model_frame(fr, fcs_e || frm_e, ab);
        vf = 1;
        for (int i = 0; i < fr.size(); i++) begin
            wr = 1; data = fr[i];
            if (i == fr.size() - 1 && eof_last && !ab) begin
                eof = 1; fcserr = fcs_e; ferr = frm_e;
            end
            clk1;
            wr = 0; eof = 0; fcserr = 0; ferr = 0;
            if (gap > 0) repeat ($urandom_range(0, gap)) clk1;
        end
        if (ab) begin
            abort = 1; clk1; abort = 0;
        end else if (!eof_last) begin
            eof = 1; fcserr = fcs_e; ferr = frm_e; clk1;
            eof = 0; fcserr = 0; ferr = 0;
        end
        vf = 0;
    endtask

    task automatic do_read;
        logic [7:0] e;
        e = 8'h00;
        if (e_busy) begin
            if (e_rdptr < e_sz) e = e_mem[e_rdptr];
            e_rdptr++;
            if (e_rdptr >= e_sz) e_busy = 0;
        end
        exp_rd.push_back(e);
        rd = 1; clk1; rd = 0;
    endtask

    task automatic do_drop;
        e_busy = 0;
        drop = 1; clk1; drop = 0;
    endtask

    function automatic bq_t rand_bytes(input int n);
        bq_t q;
        for (int i = 0; i < n; i++) q.push_back(8'($urandom));
        return q;
    endfunction

    task automatic rand_step;
        int a, n, k;
        a = $urandom_range(0, 9);
        if (a <= 5) begin
            n = ($urandom_range(0, 4) == 0) ? $urandom_range(cur_max - 3, cur_max + 4)
                                            : $urandom_range(1, 12);
            send_frame(rand_bytes(n), $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                       $urandom_range(0, 9) == 0, 1'($urandom_range(0, 1)), $urandom_range(0, 1));
        end else if (a <= 8) begin
            k = $urandom_range(1, 12);
            repeat (k) do_read;
        end else begin
            do_drop;
        end
        check_state("rand");
    endtask

    initial begin
        #10ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bq_t fr;
        exp_lost = 0; lost_seen = 0;
        sel = 0; cur_max = 128; cur_fcs = 2;
        do_reset;

        // Basic frame 0x01..0x0A
        fr.delete();
        for (int i = 1; i <= 10; i++) fr.push_back(8'(i));
        send_frame(fr, 0, 0, 0, 0, 0);
        check_state("basic_eof");
        repeat (10) do_read;
        check_state("basic_drained");

        // Overflow then clear on next frame
        send_frame(rand_bytes(130), 0, 0, 0, 1, 0);
        check_state("ovf");
        do_drop;
        send_frame(rand_bytes(6), 0, 0, 0, 0, 0);
        check_state("ovf_clear");
        repeat (4) do_read;

        // Errors and abort
        send_frame(rand_bytes(7), 1, 0, 0, 1, 0);
        check_state("fcserr");
        send_frame(rand_bytes(5), 0, 0, 1, 0, 0);
        check_state("abort");

        // Busy: second frame while first is stored
        send_frame(rand_bytes(9), 0, 0, 0, 0, 1);
        send_frame(rand_bytes(4), 0, 0, 0, 0, 0);
        check_state("busy");
        repeat (8) do_read;
        check_state("busy_drained");

        // Drop mid-drain, then a normal frame
        send_frame(rand_bytes(10), 0, 0, 0, 1, 0);
        repeat (3) do_read;
        do_drop;
        check_state("drop");
        send_frame(rand_bytes(5), 0, 0, 0, 0, 0);
        check_state("after_drop");
        repeat (4) do_read;

        repeat (40) rand_step;

        // Second configuration: 16 words, FCS-32
        sel = 1; cur_max = 16; cur_fcs = 4;
        do_reset;
        send_frame(rand_bytes(4), 0, 0, 0, 0, 0);
        check_state("fcs32_short");
        send_frame(rand_bytes(5), 0, 0, 0, 1, 0);
        check_state("fcs32_min");
        do_read; do_read;
        check_state("fcs32_min_drained");
        repeat (25) rand_step;

        // Reset mid-FILL
        while (e_busy) do_read;
        vf = 1;
        for (int i = 0; i < 3; i++) begin
            wr = 1; data = 8'($urandom); clk1;
        end
        wr = 0; vf = 0;
        do_reset;
        check_state("post_reset");

        chk("rd_queue_empty", exp_rd.size(), 0);
        chk("size_queue_empty", exp_sz.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hdlc_rx_framebuff.md
# hdlc_rx_framebuff

Parametrised receive frame buffer for the HDLC controller. It is the next generation of the fixed 128-byte, FCS-16-only Rx buffer. It sits between the Rx channel (byte strobes, end-of-frame, error flags) and the CPU register interface. It stores one frame, strips the configurable FCS trailer, and reports size, overflow and lost frames. It also serves the frame back byte-by-byte on CPU read strobes.

## Interface
Parameters:
- DATA_W, 8: data byte width.
- MAX_FRAME, 128: buffer depth in words, counted including FCS; must be ≥ 4.
- FCS_BYTES, 2: trailer words stripped from the reported size; legal values 0, 2, 4.

Ports:
- Clk  in  1  system clock; every register updates on its rising edge.
- Rst  in  1  synchronous, active-low reset.
- Rx_ValidFrame  in  1  Rx channel is inside a frame.
- Rx_WrBuff  in  1  write strobe; Rx_Data is valid this cycle.
- Rx_Data  in  DATA_W  received word.
- Rx_EoF  in  1  end-of-frame pulse.
- Rx_AbortSignal  in  1  abort detected; pulse.
- Rx_FrameError  in  1  non-octet or short frame; sampled with Rx_EoF.
- Rx_FCSerr  in  1  CRC mismatch; sampled with Rx_EoF.
- Rx_RdBuff  in  1  CPU read strobe.
- Rx_Drop  in  1  CPU discards the stored frame.
- Rx_DataBuffOut  out  DATA_W  registered read data.
- Rx_FrameSize  out  $clog2(MAX_FRAME+1)  payload words, FCS excluded.
- Rx_Ready  out  1  a complete, good frame is stored.
- Rx_Overflow  out  1  sticky; the current or last frame exceeded MAX_FRAME.
- Rx_FrameLost  out  1  one-cycle pulse; a frame was discarded (busy, error or too short).

## Operation
State machine states: IDLE, FILL, READY, DRAIN.
- IDLE:
  - Rx_WrBuff → write at address 0, count=1, go to FILL.
  - Rx_Overflow clears on this first write.
- FILL:
  - Each Rx_WrBuff writes at address count, then count++.
  - A write when count==MAX_FRAME is not stored; Rx_Overflow←1; later writes are ignored.
  - Rx_AbortSignal → IDLE, count←0, no Rx_FrameLost.
  - Rx_EoF with Rx_FrameError, Rx_FCSerr, or count≤FCS_BYTES → IDLE, Rx_FrameLost pulse.
  - Otherwise Rx_EoF → READY, Rx_FrameSize←count−FCS_BYTES.
  - With overflow set, the size saturates at MAX_FRAME−FCS_BYTES.
- READY:
  - Rx_Ready=1 and rd_ptr=0.
  - Rx_RdBuff → DRAIN and issue the read of address 0.
- DRAIN:
  - Each Rx_RdBuff reads at rd_ptr, then rd_ptr++.
  - When a read is issued with rd_ptr==Rx_FrameSize−1, go to IDLE after that read completes.
  - Rx_RdBuff with rd_ptr ≥ Rx_FrameSize → Rx_DataBuffOut←0.
- Rx_Drop in READY or DRAIN → IDLE, Rx_Ready←0. Rx_Drop has priority over Rx_RdBuff in the same cycle.
- Rx_WrBuff in READY or DRAIN: the byte is not stored. Rx_FrameLost pulses once per frame, at the first byte. The stored frame is preserved.
- Rx_RdBuff or Rx_Drop in IDLE or FILL: ignored.
- Rx_Ready stays 0 until the next good Rx_EoF.

## Timing
- Reset values: state IDLE, all pointers and counters 0, every output 0.
- Reset applies mid-frame and mid-read, discarding everything.
- Rx_Ready and Rx_FrameSize are valid the cycle after the Rx_EoF edge.
- Rx_DataBuffOut is valid the cycle after the Rx_RdBuff edge. It holds its value until the next read.
- Back-to-back Rx_RdBuff every cycle is supported.
- Rx_FrameLost is high for exactly one cycle, the cycle after the causing event.
- Rx_EoF and Rx_WrBuff in the same cycle: the write is stored first, then EoF is evaluated with count+1.
- Rx_AbortSignal and Rx_EoF in the same cycle: abort wins.

## Structure
- Package hdlc_pkg holds:
  - rxbuf_state_t enum {IDLE, FILL, READY, DRAIN};
  - FCS16_BYTES=2 and FCS32_BYTES=4;
  - a function for the size width.
- Sub-module hdlc_frame_ram:
  - simple dual-port synchronous RAM, MAX_FRAME×DATA_W;
  - one write port and one registered read port;
  - no reset on contents.
- The top holds the FSM, the counters and the flags.

## Test plan
- Basic frame, MAX_FRAME=128, FCS_BYTES=2: write 0x01..0x0A, then EoF → Rx_Ready=1, Rx_FrameSize=8. Ten reads return 0x01..0x08, then 0x00, 0x00. The block then returns to IDLE.
- Overflow: 130 writes, then good EoF → Rx_Overflow=1, Rx_FrameSize=126. Rx_Overflow clears on the next frame's first write.
- Errors and abort:
  - EoF with Rx_FCSerr=1 → Rx_Ready=0, one Rx_FrameLost pulse.
  - Abort after 5 bytes → Rx_Ready=0, no Rx_FrameLost pulse.
- Busy: a second frame arrives while READY → one Rx_FrameLost pulse. The first frame still reads back intact.
- Drop during DRAIN after 3 reads → Rx_Ready=0. A new frame is then accepted normally.
- FCS_BYTES=4, MAX_FRAME=16: a frame of 4 words → discarded with Rx_FrameLost. A frame of 5 words → Rx_FrameSize=1. Assert Rst mid-FILL → all outputs 0 on the next cycle.
